// File: rtl/ulpi_pkg.sv
// Shared ULPI PHY-emulator definitions: TX command codes, RXCMD layout and FSM states.
package ulpi_pkg;

    typedef enum logic [1:0] {
        CMD_NOOP = 2'b00,
        CMD_TX   = 2'b01,
        CMD_REGW = 2'b10,
        CMD_REGR = 2'b11
    } ulpi_cmd_e;

    localparam int RXCMD_LS_LSB   = 0;
    localparam int RXCMD_VBUS_LSB = 2;
    localparam int RXCMD_EVT_LSB  = 4;

    localparam logic [1:0] VBUS_VALID   = 2'b11;
    localparam logic [1:0] RXEVT_NONE   = 2'b00;
    localparam logic [1:0] RXEVT_ACTIVE = 2'b01;

    typedef enum logic [3:0] {
        RST_HOLD,
        IDLE,
        TX,
        TX_FLUSH,
        REGW_DATA,
        REGW_STP,
        REGR_TURN,
        REGR_DATA,
        RX_START,
        RX_DATA,
        RX_EOP,
        CMD_TURN,
        CMD_SEND
    } phy_state_e;

    function automatic logic [7:0] rxcmd(input logic [1:0] evt, input logic [1:0] ls);
        logic [7:0] r;
        r = 8'h00;
        r[RXCMD_EVT_LSB  +: 2] = evt;
        r[RXCMD_VBUS_LSB +: 2] = VBUS_VALID;
        r[RXCMD_LS_LSB   +: 2] = ls;
        return r;
    endfunction

endpackage

// File: rtl/ulpi_phy_emu_if.sv
// ULPI bus plus USB-side TX/RX AXI-Stream bundle; master = PHY emulator, slave = link/USB side.
interface ulpi_phy_emu_if;

    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic       ulpi_stp;
    logic [7:0] ulpi_data_i;
    logic [7:0] ulpi_data_o;
    logic [1:0] linestate;

    logic [7:0] usb_tx_tdata;
    logic       usb_tx_tlast;
    logic       usb_tx_tvalid;
    logic       usb_tx_tready;

    logic [7:0] usb_rx_tdata;
    logic       usb_rx_tlast;
    logic       usb_rx_tvalid;
    logic       usb_rx_tready;

    modport master (
        output ulpi_dir, ulpi_nxt, ulpi_data_o,
        output usb_tx_tdata, usb_tx_tlast, usb_tx_tvalid, usb_rx_tready,
        input  ulpi_stp, ulpi_data_i, linestate,
        input  usb_tx_tready, usb_rx_tdata, usb_rx_tlast, usb_rx_tvalid
    );

    modport slave (
        input  ulpi_dir, ulpi_nxt, ulpi_data_o,
        input  usb_tx_tdata, usb_tx_tlast, usb_tx_tvalid, usb_rx_tready,
        output ulpi_stp, ulpi_data_i, linestate,
        output usb_tx_tready, usb_rx_tdata, usb_rx_tlast, usb_rx_tvalid
    );

endinterface

// File: rtl/ulpi_phy_regfile.sv
// ULPI register file: one synchronous write port, one async read port; out-of-range reads 00h.
module ulpi_phy_regfile #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [5:0] waddr,
    input  logic [7:0] wdata,
    input  logic [5:0] raddr,
    output logic [7:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][7:0] mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (we && int'(waddr) < DEPTH)
            mem[waddr[AW-1:0]] <= wdata;
    end

    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/ulpi_phy_emu.sv
// PHY-side ULPI responder. Define ULPI_PHY_EMU_REGS_EN to back RegWrite/RegRead with real storage;
// otherwise the register handshakes still run with identical timing and reads return 00h.
module ulpi_phy_emu
    import ulpi_pkg::*;
#(
    parameter int REG_DEPTH = 16
) (
    input logic              clk,
    input logic              rst,
    ulpi_phy_emu_if.master   bus
);

    phy_state_e state, state_nx;

    logic [7:0] hold_q, out_data_q;
    logic       out_last_q, out_valid_q;
    logic       dir_q, drop_q;
    logic [1:0] last_ls_q;

    logic       dir, nxt;
    logic [7:0] data_o, reg_rdata;
    logic       room, push, push_last, pid_ld, hold_ld;
    logic       addr_ld, wdata_ld, reg_we, ls_upd, drop_set, rx_take;

    // Output register may take a new byte if empty or draining this cycle.
    assign room = ~out_valid_q | bus.usb_tx_tready;

    always_comb begin
        state_nx  = state;
        dir       = 1'b0;
        nxt       = 1'b0;
        data_o    = 8'h00;
        push      = 1'b0;
        push_last = 1'b0;
        pid_ld    = 1'b0;
        hold_ld   = 1'b0;
        addr_ld   = 1'b0;
        wdata_ld  = 1'b0;
        reg_we    = 1'b0;
        ls_upd    = 1'b0;
        drop_set  = 1'b0;
        rx_take   = 1'b0;
        case (state)
            RST_HOLD: begin
                dir      = 1'b1;
                state_nx = IDLE;
            end
            IDLE: begin
                // dir_q high marks the turnaround cycle after dir fell
                if (!dir_q) begin
                    case (ulpi_cmd_e'(bus.ulpi_data_i[7:6]))
                        CMD_TX: begin
                            nxt = 1'b1; pid_ld = 1'b1; state_nx = TX;
                        end
                        CMD_REGW: begin
                            nxt = 1'b1; addr_ld = 1'b1; state_nx = REGW_DATA;
                        end
                        CMD_REGR: begin
                            nxt = 1'b1; addr_ld = 1'b1; state_nx = REGR_TURN;
                        end
                        default: begin
                            if (bus.usb_rx_tvalid && !drop_q)
                                state_nx = RX_START;
                            else if (bus.linestate != last_ls_q)
                                state_nx = CMD_TURN;
                        end
                    endcase
                end
            end
            TX: begin
                if (bus.ulpi_stp) begin
                    if (room) begin
                        push = 1'b1; push_last = 1'b1; state_nx = IDLE;
                    end else begin
                        state_nx = TX_FLUSH;
                    end
                end else if (room) begin
                    nxt = 1'b1; push = 1'b1; hold_ld = 1'b1;
                end
            end
            TX_FLUSH: begin
                if (room) begin
                    push = 1'b1; push_last = 1'b1; state_nx = IDLE;
                end
            end
            REGW_DATA: begin
                nxt = 1'b1; wdata_ld = 1'b1; state_nx = REGW_STP;
            end
            REGW_STP: begin
                if (bus.ulpi_stp) begin
                    reg_we = 1'b1; state_nx = IDLE;
                end
            end
            REGR_TURN: begin
                dir = 1'b1; state_nx = REGR_DATA;
            end
            REGR_DATA: begin
                dir = 1'b1; data_o = reg_rdata; state_nx = IDLE;
            end
            RX_START: begin
                dir = 1'b1; nxt = 1'b1; state_nx = RX_DATA;
            end
            RX_DATA: begin
                dir = 1'b1;
                if (bus.ulpi_stp) begin
                    data_o = rxcmd(RXEVT_ACTIVE, bus.linestate); ls_upd = 1'b1;
                    drop_set = 1'b1; state_nx = IDLE;
                end else if (bus.usb_rx_tvalid) begin
                    nxt = 1'b1; data_o = bus.usb_rx_tdata; rx_take = 1'b1;
                    if (bus.usb_rx_tlast) state_nx = RX_EOP;
                end else begin
                    data_o = rxcmd(RXEVT_ACTIVE, bus.linestate); ls_upd = 1'b1;
                end
            end
            RX_EOP: begin
                dir = 1'b1; data_o = rxcmd(RXEVT_NONE, bus.linestate); ls_upd = 1'b1;
                state_nx = IDLE;
            end
            CMD_TURN: begin
                dir = 1'b1; state_nx = CMD_SEND;
            end
            CMD_SEND: begin
                dir = 1'b1; data_o = rxcmd(RXEVT_NONE, bus.linestate); ls_upd = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RST_HOLD;
            dir_q       <= 1'b1;
            hold_q      <= 8'h00;
            out_data_q  <= 8'h00;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            last_ls_q   <= 2'b00;
            drop_q      <= 1'b0;
        end else begin
            state <= state_nx;
            dir_q <= dir;
            if (pid_ld)
                hold_q <= {~bus.ulpi_data_i[3:0], bus.ulpi_data_i[3:0]};
            else if (hold_ld)
                hold_q <= bus.ulpi_data_i;
            if (push) begin
                out_data_q  <= hold_q;
                out_last_q  <= push_last;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.usb_tx_tready) begin
                out_valid_q <= 1'b0;
            end
            if (ls_upd)
                last_ls_q <= bus.linestate;
            if (drop_set)
                drop_q <= 1'b1;
            else if (drop_q && bus.usb_rx_tvalid && bus.usb_rx_tlast)
                drop_q <= 1'b0;
        end
    end

`ifdef ULPI_PHY_EMU_REGS_EN
    logic [5:0] addr_q;
    logic [7:0] wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= 6'd0;
            wdata_q <= 8'h00;
        end else begin
            if (addr_ld)  addr_q  <= bus.ulpi_data_i[5:0];
            if (wdata_ld) wdata_q <= bus.ulpi_data_i;
        end
    end

    ulpi_phy_regfile #(.DEPTH(REG_DEPTH)) u_regs (
        .clk   (clk),
        .rst   (rst),
        .we    (reg_we),
        .waddr (addr_q),
        .wdata (wdata_q),
        .raddr (addr_q),
        .rdata (reg_rdata)
    );
`else
    logic regs_unused;
    assign regs_unused = ^{addr_ld, wdata_ld, reg_we, REG_DEPTH[0]};
    assign reg_rdata   = 8'h00;
`endif

    assign bus.ulpi_dir      = dir;
    assign bus.ulpi_nxt      = nxt;
    assign bus.ulpi_data_o   = data_o;
    assign bus.usb_tx_tdata  = out_data_q;
    assign bus.usb_tx_tlast  = out_last_q;
    assign bus.usb_tx_tvalid = out_valid_q;
    assign bus.usb_rx_tready = rx_take | drop_q;

endmodule

// File: tb/tb_ulpi_phy_emu.sv
// Directed bench for ulpi_phy_emu: TX, backpressure/flush, register access, RXCMD, RX, RX abort, async reset.
module tb_ulpi_phy_emu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

`ifdef ULPI_PHY_EMU_REGS_EN
    localparam logic [7:0] RD_EXP = 8'h5A;
`else
    localparam logic [7:0] RD_EXP = 8'h00;
`endif

    ulpi_phy_emu_if bus ();

    ulpi_phy_emu #(.REG_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic ph(input string tag, input logic d, input logic n, input logic [7:0] o);
        chk({tag, ".dir"},  {7'd0, bus.ulpi_dir}, {7'd0, d});
        chk({tag, ".nxt"},  {7'd0, bus.ulpi_nxt}, {7'd0, n});
        chk({tag, ".data"}, bus.ulpi_data_o, o);
    endtask

    task automatic txb(input string tag, input logic [7:0] d, input logic l);
        chk({tag, ".tvalid"}, {7'd0, bus.usb_tx_tvalid}, 8'h01);
        chk({tag, ".tdata"},  bus.usb_tx_tdata, d);
        chk({tag, ".tlast"},  {7'd0, bus.usb_tx_tlast}, {7'd0, l});
    endtask

    task automatic txv0(input string tag);
        chk({tag, ".tvalid"}, {7'd0, bus.usb_tx_tvalid}, 8'h00);
    endtask

    task automatic rdy(input string tag, input logic r);
        chk({tag, ".rx_tready"}, {7'd0, bus.usb_rx_tready}, {7'd0, r});
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        bus.ulpi_stp      = 1'b0;
        bus.ulpi_data_i   = 8'h00;
        bus.linestate     = 2'b00;
        bus.usb_tx_tready = 1'b1;
        bus.usb_rx_tdata  = 8'h00;
        bus.usb_rx_tlast  = 1'b0;
        bus.usb_rx_tvalid = 1'b0;

        // reset state
        smp(); ph("rst", 1'b1, 1'b0, 8'h00); txv0("rst"); rdy("rst", 1'b0);
        nx(); rst = 1'b0;
        smp(); ph("hold", 1'b1, 1'b0, 8'h00);
        nx(); smp(); ph("turn0", 1'b0, 1'b0, 8'h00);

        // transmit 43h, 11h, 22h, stp
        nx(); bus.ulpi_data_i = 8'h43; smp(); ph("tx.cmd", 1'b0, 1'b1, 8'h00);
        nx(); bus.ulpi_data_i = 8'h11; smp(); ph("tx.b1", 1'b0, 1'b1, 8'h00); txv0("tx.b1");
        nx(); bus.ulpi_data_i = 8'h22; smp(); ph("tx.b2", 1'b0, 1'b1, 8'h00); txb("tx.pid", 8'hC3, 1'b0);
        nx(); bus.ulpi_data_i = 8'h00; bus.ulpi_stp = 1'b1;
        smp(); ph("tx.stp", 1'b0, 1'b0, 8'h00); txb("tx.o11", 8'h11, 1'b0);
        nx(); bus.ulpi_stp = 1'b0; smp(); txb("tx.o22", 8'h22, 1'b1);

        // same packet with backpressure, then stp while output blocked
        nx(); bus.ulpi_data_i = 8'h43; smp(); ph("bp.cmd", 1'b0, 1'b1, 8'h00); txv0("bp.cmd");
        nx(); bus.ulpi_data_i = 8'h11; smp(); ph("bp.b1", 1'b0, 1'b1, 8'h00);
        for (int k = 0; k < 4; k++) begin
            nx(); bus.ulpi_data_i = 8'h22; bus.usb_tx_tready = 1'b0;
            smp(); ph("bp.stall", 1'b0, 1'b0, 8'h00); txb("bp.stall", 8'hC3, 1'b0);
        end
        nx(); bus.usb_tx_tready = 1'b1; smp(); ph("bp.b2", 1'b0, 1'b1, 8'h00); txb("bp.pid", 8'hC3, 1'b0);
        nx(); bus.ulpi_data_i = 8'h00; bus.ulpi_stp = 1'b1; bus.usb_tx_tready = 1'b0;
        smp(); ph("bp.stp", 1'b0, 1'b0, 8'h00); txb("bp.o11a", 8'h11, 1'b0);
        nx(); bus.ulpi_stp = 1'b0; bus.usb_tx_tready = 1'b1;
        smp(); ph("bp.flush", 1'b0, 1'b0, 8'h00); txb("bp.o11b", 8'h11, 1'b0);
        nx(); smp(); txb("bp.o22", 8'h22, 1'b1);

        // RegWrite 84h/5Ah, then RegRead C4h
        nx(); bus.ulpi_data_i = 8'h84; smp(); ph("rw.cmd", 1'b0, 1'b1, 8'h00); txv0("rw.cmd");
        nx(); bus.ulpi_data_i = 8'h5A; smp(); ph("rw.data", 1'b0, 1'b1, 8'h00);
        nx(); bus.ulpi_data_i = 8'h00; bus.ulpi_stp = 1'b1; smp(); ph("rw.stp", 1'b0, 1'b0, 8'h00);
        nx(); bus.ulpi_stp = 1'b0; bus.ulpi_data_i = 8'hC4; smp(); ph("rr.cmd", 1'b0, 1'b1, 8'h00);
        nx(); bus.ulpi_data_i = 8'h00; smp(); ph("rr.turn", 1'b1, 1'b0, 8'h00);
        nx(); smp(); ph("rr.data", 1'b1, 1'b0, RD_EXP);
        nx(); smp(); ph("rr.turn2", 1'b0, 1'b0, 8'h00);

        // linestate change reported once
        nx(); bus.linestate = 2'b01; smp(); ph("ls.idle", 1'b0, 1'b0, 8'h00);
        nx(); smp(); ph("ls.turn", 1'b1, 1'b0, 8'h00);
        nx(); smp(); ph("ls.cmd", 1'b1, 1'b0, 8'h0D);
        nx(); smp(); ph("ls.turn2", 1'b0, 1'b0, 8'h00);
        for (int k = 0; k < 3; k++) begin
            nx(); smp(); ph("ls.stable", 1'b0, 1'b0, 8'h00);
        end

        // RX: A1, gap of 2, A2, A3(last)
        nx(); bus.usb_rx_tvalid = 1'b1; bus.usb_rx_tdata = 8'hA1;
        smp(); ph("rx.idle", 1'b0, 1'b0, 8'h00); rdy("rx.idle", 1'b0);
        nx(); smp(); ph("rx.start", 1'b1, 1'b1, 8'h00); rdy("rx.start", 1'b0);
        nx(); smp(); ph("rx.a1", 1'b1, 1'b1, 8'hA1); rdy("rx.a1", 1'b1);
        nx(); bus.usb_rx_tvalid = 1'b0; smp(); ph("rx.gap1", 1'b1, 1'b0, 8'h1D);
        nx(); smp(); ph("rx.gap2", 1'b1, 1'b0, 8'h1D);
        nx(); bus.usb_rx_tvalid = 1'b1; bus.usb_rx_tdata = 8'hA2;
        smp(); ph("rx.a2", 1'b1, 1'b1, 8'hA2); rdy("rx.a2", 1'b1);
        nx(); bus.usb_rx_tdata = 8'hA3; bus.usb_rx_tlast = 1'b1; smp(); ph("rx.a3", 1'b1, 1'b1, 8'hA3);
        nx(); bus.usb_rx_tvalid = 1'b0; bus.usb_rx_tlast = 1'b0; smp(); ph("rx.eop", 1'b1, 1'b0, 8'h0D);
        nx(); smp(); ph("rx.turn", 1'b0, 1'b0, 8'h00);

        // RX aborted by stp after byte 1 of 5; rest drained, next packet delivered
        nx(); bus.usb_rx_tvalid = 1'b1; bus.usb_rx_tdata = 8'hB1; smp(); ph("ab.idle", 1'b0, 1'b0, 8'h00);
        nx(); smp(); ph("ab.start", 1'b1, 1'b1, 8'h00);
        nx(); smp(); ph("ab.b1", 1'b1, 1'b1, 8'hB1);
        nx(); bus.usb_rx_tdata = 8'hB2; bus.ulpi_stp = 1'b1;
        smp(); chk("ab.stp.dir", {7'd0, bus.ulpi_dir}, 8'h01); chk("ab.stp.nxt", {7'd0, bus.ulpi_nxt}, 8'h00);
        rdy("ab.stp", 1'b0);
        nx(); bus.ulpi_stp = 1'b0; smp(); ph("ab.b2", 1'b0, 1'b0, 8'h00); rdy("ab.b2", 1'b1);
        for (int k = 0; k < 3; k++) begin
            nx(); bus.usb_rx_tdata = 8'hB3 + 8'(k); bus.usb_rx_tlast = (k == 2);
            smp(); ph("ab.drain", 1'b0, 1'b0, 8'h00); rdy("ab.drain", 1'b1);
        end
        nx(); bus.usb_rx_tdata = 8'hC1; bus.usb_rx_tlast = 1'b1;
        smp(); ph("nx.idle", 1'b0, 1'b0, 8'h00); rdy("nx.idle", 1'b0);
        nx(); smp(); ph("nx.start", 1'b1, 1'b1, 8'h00);
        nx(); smp(); ph("nx.c1", 1'b1, 1'b1, 8'hC1); rdy("nx.c1", 1'b1);
        nx(); bus.usb_rx_tvalid = 1'b0; bus.usb_rx_tlast = 1'b0; smp(); ph("nx.eop", 1'b1, 1'b0, 8'h0D);
        nx(); smp(); ph("nx.turn", 1'b0, 1'b0, 8'h00);

        // async reset in the middle of a transmit
        nx(); bus.ulpi_data_i = 8'h43; smp(); ph("ar.cmd", 1'b0, 1'b1, 8'h00);
        nx(); bus.ulpi_data_i = 8'h11; smp();
        nx(); bus.ulpi_data_i = 8'h22; smp(); txb("ar.pid", 8'hC3, 1'b0);
        #2 rst = 1'b1;
        #1 ph("ar.rst", 1'b1, 1'b0, 8'h00); txv0("ar.rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
